// File: rtl/score_pkg.sv
// Shared types, segment tables and the BCD magnitude compare for the score display.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [6:0] seg_t;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    BLINK   = 2'd2
  } disp_state_t;

  // Strict BCD magnitude compare, most significant digit first
  function automatic logic bcd_gt(input bcd_digit_t a_h, input bcd_digit_t a_t,
                                  input bcd_digit_t a_o, input bcd_digit_t b_h,
                                  input bcd_digit_t b_t, input bcd_digit_t b_o);
    logic gt;
    if (a_h != b_h)      gt = (a_h > b_h);
    else if (a_t != b_t) gt = (a_t > b_t);
    else                 gt = (a_o > b_o);
    return gt;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD digit to an active-low seven-segment pattern; out-of-range digits show a dash.
module bcd_to_seg
  import score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (blank)              seg = SEG_BLANK;
    else if (digit > 4'd9)  seg = SEG_DASH;
    else                    seg = SEG_DIGIT[digit];
  end

endmodule

// File: rtl/score_hex_display.sv
// Drives six HEX displays with the live score and the session high score,
// capturing and blinking a new high score at the end of each game.
module score_hex_display
  import score_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned BLINK_HZ      = 2,
  parameter int unsigned BLINK_TOGGLES = 6
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_ones,
  input  logic [3:0] score_tens,
  input  logic [3:0] score_hundreds,
  input  logic       game_over,
  input  logic       hs_clear,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [3:0] hs_ones,
  output logic [3:0] hs_tens,
  output logic [3:0] hs_hundreds,
  output logic       new_high
);

  localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned TGL_W = $clog2(BLINK_TOGGLES + 1);

  disp_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TGL_W-1:0] tgl_q, tgl_d;
  logic             phase_on_q, phase_on_d;
  bcd_digit_t       hs_o_d, hs_t_d, hs_h_d;
  bcd_digit_t       sq_o, sq_t, sq_h;
  logic             score_gt;

  seg_t seg0_c, seg1_c, seg2_c, seg3_c, seg4_c, seg5_c;

  assign score_gt = bcd_gt(sq_h, sq_t, sq_o, hs_hundreds, hs_tens, hs_ones);

  // Next-state, high score capture and blink timing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgl_d      = tgl_q;
    phase_on_d = phase_on_q;
    hs_o_d     = hs_ones;
    hs_t_d     = hs_tens;
    hs_h_d     = hs_hundreds;
    if (hs_clear) begin
      state_d    = IDLE;
      cnt_d      = '0;
      tgl_d      = '0;
      phase_on_d = 1'b1;
      hs_o_d     = 4'd0;
      hs_t_d     = 4'd0;
      hs_h_d     = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (game_over) state_d = COMPARE;
        end
        COMPARE: begin
          if (score_gt) begin
            hs_o_d     = sq_o;
            hs_t_d     = sq_t;
            hs_h_d     = sq_h;
            cnt_d      = '0;
            tgl_d      = '0;
            phase_on_d = 1'b1;
            state_d    = BLINK;
          end else begin
            state_d = IDLE;
          end
        end
        BLINK: begin
          if (game_over) begin
            state_d    = COMPARE;
            cnt_d      = '0;
            phase_on_d = 1'b1;
          end else if (cnt_q == CNT_W'(HALF - 1)) begin
            cnt_d = '0;
            tgl_d = tgl_q + TGL_W'(1);
            if (tgl_q + TGL_W'(1) == TGL_W'(BLINK_TOGGLES)) begin
              state_d    = IDLE;
              phase_on_d = 1'b1;
            end else begin
              phase_on_d = ~phase_on_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tgl_q       <= '0;
      phase_on_q  <= 1'b1;
      hs_ones     <= 4'd0;
      hs_tens     <= 4'd0;
      hs_hundreds <= 4'd0;
      new_high    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgl_q       <= tgl_d;
      phase_on_q  <= phase_on_d;
      hs_ones     <= hs_o_d;
      hs_tens     <= hs_t_d;
      hs_hundreds <= hs_h_d;
      new_high    <= (state_d == BLINK);
    end
  end

  // Score input stage and registered segment outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_o <= 4'd0;
      sq_t <= 4'd0;
      sq_h <= 4'd0;
      hex0 <= SEG_BLANK;
      hex1 <= SEG_BLANK;
      hex2 <= SEG_BLANK;
      hex3 <= SEG_BLANK;
      hex4 <= SEG_BLANK;
      hex5 <= SEG_BLANK;
    end else begin
      sq_o <= score_ones;
      sq_t <= score_tens;
      sq_h <= score_hundreds;
      hex0 <= seg0_c;
      hex1 <= seg1_c;
      hex2 <= seg2_c;
      hex3 <= seg3_c;
      hex4 <= seg4_c;
      hex5 <= seg5_c;
    end
  end

  // Leading-zero blanking per triplet; the off blink phase blanks only the high score
  bcd_to_seg u_seg0 (.digit(sq_o), .blank(1'b0), .seg(seg0_c));
  bcd_to_seg u_seg1 (.digit(sq_t), .blank((sq_h == 4'd0) && (sq_t == 4'd0)), .seg(seg1_c));
  bcd_to_seg u_seg2 (.digit(sq_h), .blank(sq_h == 4'd0), .seg(seg2_c));
  bcd_to_seg u_seg3 (.digit(hs_ones), .blank(~phase_on_q), .seg(seg3_c));
  bcd_to_seg u_seg4 (.digit(hs_tens),
                     .blank(~phase_on_q || ((hs_hundreds == 4'd0) && (hs_tens == 4'd0))),
                     .seg(seg4_c));
  bcd_to_seg u_seg5 (.digit(hs_hundreds), .blank(~phase_on_q || (hs_hundreds == 4'd0)),
                     .seg(seg5_c));

endmodule

// File: tb/tb_score_hex_display.sv
// Directed bench for score_hex_display with a 4-cycle blink half-period.
module tb_score_hex_display;
  import score_pkg::*;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DA = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] score_ones = 4'd0, score_tens = 4'd0, score_hundreds = 4'd0;
  logic       game_over = 1'b0, hs_clear = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [3:0] hs_ones, hs_tens, hs_hundreds;
  logic       new_high;

  int checks = 0;
  int errors = 0;

  score_hex_display #(.CLK_HZ(8), .BLINK_HZ(1), .BLINK_TOGGLES(6)) dut (
    .clk(clk), .rst(rst),
    .score_ones(score_ones), .score_tens(score_tens), .score_hundreds(score_hundreds),
    .game_over(game_over), .hs_clear(hs_clear),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .hs_ones(hs_ones), .hs_tens(hs_tens), .hs_hundreds(hs_hundreds),
    .new_high(new_high)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_score(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    score_hundreds = h;
    score_tens     = t;
    score_ones     = o;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {6{BL}}) begin
      errors++;
      $display("FAIL reset_hex got %h want %h", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{BL}});
    end
    checks++;
    if ({hs_hundreds, hs_tens, hs_ones, new_high} !== 13'd0) begin
      errors++;
      $display("FAIL reset_hs got %h%h%h nh %b want 000 nh 0", hs_hundreds, hs_tens, hs_ones, new_high);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({hex2, hex1, hex0} !== {BL, BL, S0}) begin
      errors++;
      $display("FAIL post_reset_score got %h want %h", {hex2, hex1, hex0}, {BL, BL, S0});
    end
    checks++;
    if ({hex5, hex4, hex3, new_high} !== {BL, BL, S0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_hs got %h want %h", {hex5, hex4, hex3, new_high}, {BL, BL, S0, 1'b0});
    end
  endtask

  task automatic test_blanking();
    set_score(4'd0, 4'd0, 4'd7);
    tick();
    checks++;
    if (hex0 !== S0) begin
      errors++;
      $display("FAIL latency_1cycle hex0 got %h want %h", hex0, S0);
    end
    tick();
    checks++;
    if ({hex2, hex1, hex0} !== {BL, BL, S7}) begin
      errors++;
      $display("FAIL score_007 got %h want %h", {hex2, hex1, hex0}, {BL, BL, S7});
    end
    set_score(4'd1, 4'd0, 4'd5);
    tick();
    tick();
    checks++;
    if ({hex2, hex1, hex0} !== {S1, S0, S5}) begin
      errors++;
      $display("FAIL score_105 got %h want %h", {hex2, hex1, hex0}, {S1, S0, S5});
    end
    set_score(4'd1, 4'd0, 4'hC);
    tick();
    tick();
    checks++;
    if ({hex2, hex1, hex0} !== {S1, S0, DA}) begin
      errors++;
      $display("FAIL score_dash got %h want %h", {hex2, hex1, hex0}, {S1, S0, DA});
    end
  endtask

  task automatic test_new_high();
    logic       on;
    logic [20:0] exp_hex;
    set_score(4'd1, 4'd2, 4'd8);
    tick();
    tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    checks++;
    if (dut.state_q !== COMPARE || new_high !== 1'b0) begin
      errors++;
      $display("FAIL nh_compare state %0d nh %b want state 1 nh 0", dut.state_q, new_high);
    end
    tick();
    checks++;
    if ({hs_hundreds, hs_tens, hs_ones, new_high} !== {12'h128, 1'b1}) begin
      errors++;
      $display("FAIL nh_capture got %h%h%h nh %b want 128 nh 1", hs_hundreds, hs_tens, hs_ones, new_high);
    end
    for (int k = 2; k <= 26; k++) begin
      tick();
      on = (((k - 2) / 4) % 2) == 0;
      exp_hex = on ? {S1, S2, S8} : {BL, BL, BL};
      checks++;
      if ({hex5, hex4, hex3} !== exp_hex || new_high !== (k <= 24)) begin
        errors++;
        $display("FAIL nh_blink k=%0d hex %h nh %b want hex %h nh %b",
                 k, {hex5, hex4, hex3}, new_high, exp_hex, (k <= 24));
      end
    end
  endtask

  task automatic test_not_higher();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        set_score(4'd0, 4'd9, 4'd9);
        tick();
        tick();
      end
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
      checks++;
      if (dut.state_q !== COMPARE || new_high !== 1'b0) begin
        errors++;
        $display("FAIL nothigher_compare pass %0d state %0d nh %b want state 1 nh 0",
                 pass, dut.state_q, new_high);
      end
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (dut.state_q !== IDLE || new_high !== 1'b0 ||
            {hs_hundreds, hs_tens, hs_ones} !== 12'h128 || {hex5, hex4, hex3} !== {S1, S2, S8}) begin
          errors++;
          $display("FAIL nothigher_hold pass %0d c %0d state %0d nh %b hs %h%h%h hex %h want IDLE 0 128 %h",
                   pass, c, dut.state_q, new_high, hs_hundreds, hs_tens, hs_ones,
                   {hex5, hex4, hex3}, {S1, S2, S8});
        end
      end
    end
  endtask

  task automatic test_abort();
    logic        on;
    logic [20:0] exp_hex;
    set_score(4'd1, 4'd5, 4'd0);
    tick();
    tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    set_score(4'd2, 4'd0, 4'd0);
    tick();
    checks++;
    if ({hs_hundreds, hs_tens, hs_ones, new_high} !== {12'h150, 1'b1}) begin
      errors++;
      $display("FAIL abort_first got %h%h%h nh %b want 150 nh 1", hs_hundreds, hs_tens, hs_ones, new_high);
    end
    for (int c = 0; c < 8; c++) tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    checks++;
    if (new_high !== 1'b0 || dut.state_q !== COMPARE) begin
      errors++;
      $display("FAIL abort_drop nh %b state %0d want nh 0 state 1", new_high, dut.state_q);
    end
    tick();
    checks++;
    if ({hs_hundreds, hs_tens, hs_ones, new_high} !== {12'h200, 1'b1}) begin
      errors++;
      $display("FAIL abort_recapture got %h%h%h nh %b want 200 nh 1", hs_hundreds, hs_tens, hs_ones, new_high);
    end
    for (int k = 2; k <= 26; k++) begin
      tick();
      on = (((k - 2) / 4) % 2) == 0;
      exp_hex = on ? {S2, S0, S0} : {BL, BL, BL};
      checks++;
      if ({hex5, hex4, hex3} !== exp_hex || new_high !== (k <= 24)) begin
        errors++;
        $display("FAIL abort_blink k=%0d hex %h nh %b want hex %h nh %b",
                 k, {hex5, hex4, hex3}, new_high, exp_hex, (k <= 24));
      end
    end
  endtask

  task automatic test_clear_priority();
    set_score(4'd3, 4'd0, 4'd0);
    tick();
    tick();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (new_high !== 1'b1 || {hex5, hex4, hex3} !== {BL, BL, BL}) begin
      errors++;
      $display("FAIL clear_setup nh %b hex %h want nh 1 hex %h", new_high, {hex5, hex4, hex3}, {BL, BL, BL});
    end
    hs_clear  = 1'b1;
    game_over = 1'b1;
    tick();
    hs_clear  = 1'b0;
    game_over = 1'b0;
    checks++;
    if ({hs_hundreds, hs_tens, hs_ones, new_high} !== 13'd0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL clear_now hs %h%h%h nh %b state %0d want 000 0 IDLE",
               hs_hundreds, hs_tens, hs_ones, new_high, dut.state_q);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({hex5, hex4, hex3} !== {BL, BL, S0} || dut.state_q !== IDLE || new_high !== 1'b0 ||
          {hs_hundreds, hs_tens, hs_ones} !== 12'h000) begin
        errors++;
        $display("FAIL clear_hold c %0d hex %h state %0d nh %b hs %h%h%h want %h IDLE 0 000",
                 c, {hex5, hex4, hex3}, dut.state_q, new_high, hs_hundreds, hs_tens, hs_ones,
                 {BL, BL, S0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_blanking();
    test_new_high();
    test_not_higher();
    test_abort();
    test_clear_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
